temporal_encoder: RTL and testbench
===================================

Name: temporal_encoder

Overview:
Upstream stage of the temporal filter array. Accepts one vector of binary spike times per gamma cycle through a valid/ready handshake and converts each lane into a rising-edge race-logic signal. Also generates the two threshold edges `sel_greater` and `sel_lesser`, and a gamma-reset strobe that clears the downstream comparators. Edges are monotonic: once high, a lane stays high until the next gamma clear.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, number of RUN clock cycles per gamma cycle (G).
- NUM_INPUTS, GAMMA_CYCLE_WIDTH, number of encoded lanes.
- TIME_WIDTH, $clog2(GAMMA_CYCLE_WIDTH)+1, width of each spike-time field. Any value >= G means "no spike".

Ports:
- aclk  input  1  clock.
- grst  input  1  synchronous active-low reset.
- in_valid  input  1  spike-time vector valid.
- in_ready  output  1  encoder can accept a vector.
- in_times  input  NUM_INPUTS*TIME_WIDTH  lane i time = bits [i*TIME_WIDTH +: TIME_WIDTH].
- in_t_greater  input  TIME_WIDTH  time of the `sel_greater` edge.
- in_t_lesser  input  TIME_WIDTH  time of the `sel_lesser` edge.
- edges  output  NUM_INPUTS  per-lane race-logic edges to the filter.
- sel_greater  output  1  threshold edge to the filter.
- sel_lesser  output  1  threshold edge to the filter.
- gamma_rst_n  output  1  active-low gamma clear for the downstream stage.
- busy  output  1  high in CLEAR or RUN.
- cycle_done  output  1  one-cycle pulse in the last RUN cycle.

Behaviour:
- Clock and reset: one clock (`aclk`); reset `grst` is synchronous, active-low, sampled on the `aclk` rising edge.
- Reset (`grst`==0 at a posedge):
  - state=IDLE, cnt=0, stored times cleared.
  - edges=0, sel_greater=0, sel_lesser=0, busy=0, cycle_done=0, gamma_rst_n=0.
  - in_ready is combinationally 0 while `grst`==0.
- FSM states: IDLE, CLEAR, RUN.
- IDLE:
  - in_ready=1.
  - Handshake completes when in_valid&&in_ready at a posedge. All of `in_times`, `in_t_greater` and `in_t_lesser` are captured into registers. Next state is CLEAR.
  - Outputs hold the values left by the previous gamma cycle.
  - gamma_rst_n=1.
- CLEAR: exactly one cycle.
  - gamma_rst_n=0, edges=0, sel_greater=0, sel_lesser=0, cnt<=0, busy=1.
  - Next state is RUN.
- RUN: cnt counts 0..G-1, one increment per cycle.
  - In the RUN cycle where cnt==k: edges[i]=(time_i<=k), sel_greater=(t_greater<=k), sel_lesser=(t_lesser<=k).
  - Compare at full TIME_WIDTH, unsigned. Time 0 rises in the first RUN cycle. Time >= G never rises.
  - cycle_done=1 only when cnt==G-1. The next state after that cycle is IDLE.
- Latency: handshake at posedge n gives CLEAR in cycle n+1, RUN k=0..G-1 in cycles n+2..n+1+G, and in_ready=1 again in cycle n+2+G.
- Output timing: all outputs except in_ready are registered, glitch-free, and change only on `aclk` edges. Edges are monotonic within a RUN and never fall except via CLEAR or reset.
- Handshake:
  - in_ready=0 in CLEAR and RUN; in_valid in those states is ignored.
  - The producer holds data stable while in_valid&&!in_ready.
  - No vector is lost or duplicated.
- Back-to-back transfers: a vector held valid is accepted in the first IDLE cycle. Its CLEAR then drops the previous edges for exactly one cycle.
- Reset mid-CLEAR or mid-RUN:
  - Aborts the transfer; all outputs take their reset values on the next edge.
  - No cycle_done is produced.
  - The captured vector is discarded.
- cnt width: $clog2(GAMMA_CYCLE_WIDTH). No wrap beyond G-1; the counter rests at 0 in IDLE.

Test Plan:
1. Reset: hold `grst` low for 3 cycles mid-stream -> edges=0, sel_*=0, gamma_rst_n=0, in_ready=0, busy=0. One cycle after release -> in_ready=1, gamma_rst_n=1.
2. Basic encode (G=16, NUM_INPUTS=4): times {0,3,15,16}, t_greater=5, t_lesser=9, handshake at cycle n:
   - CLEAR at n+1.
   - edges[0] rises at n+2, edges[1] at n+5, edges[2] at n+17; edges[3] stays 0.
   - sel_greater rises at n+7, sel_lesser at n+11.
   - cycle_done at n+17; in_ready=1 at n+18.
3. Backpressure: raise in_valid with times all 2 at RUN k=4 and hold it -> ignored until IDLE. Accepted at n+18; a CLEAR with edges=0 and gamma_rst_n=0 follows at n+19.
4. No-spike: all times = 31 (TIME_WIDTH=5), t_greater=16, t_lesser=0 -> edges stay 0 for the full gamma cycle, sel_greater stays 0, sel_lesser high from k=0.
5. Reset mid-RUN: assert `grst`=0 at RUN k=7 -> next cycle all outputs are 0, state is IDLE, no cycle_done. After release the next vector encodes normally.
6. Monotonicity soak: 200 random vectors with random in_valid gaps -> assert every edge rises at exactly its time, never falls in RUN, and exactly one cycle_done per accepted vector.

Source files
------------

// File: rtl/temporal_encoder.sv
// temporal_encoder: turns one vector of binary spike times per gamma cycle into
// monotonic race-logic rising edges, plus the two threshold edges and a gamma clear.
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
  parameter int TIME_WIDTH        = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                             aclk,
  input  logic                             grst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*TIME_WIDTH-1:0] in_times,
  input  logic [TIME_WIDTH-1:0]            in_t_greater,
  input  logic [TIME_WIDTH-1:0]            in_t_lesser,
  output logic [NUM_INPUTS-1:0]            edges,
  output logic                             sel_greater,
  output logic                             sel_lesser,
  output logic                             gamma_rst_n,
  output logic                             busy,
  output logic                             cycle_done
);

  localparam int CNT_WIDTH = $clog2(GAMMA_CYCLE_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                           state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0]             cnt_r, cnt_nxt_s;
  logic [NUM_INPUTS*TIME_WIDTH-1:0] times_r;
  logic [TIME_WIDTH-1:0]            t_greater_r, t_lesser_r;
  logic [TIME_WIDTH-1:0]            cnt_ext_s;
  logic [NUM_INPUTS-1:0]            edges_r, edges_nxt_s;
  logic                             sel_greater_r, sel_greater_nxt_s;
  logic                             sel_lesser_r, sel_lesser_nxt_s;
  logic                             gamma_rst_n_r, gamma_rst_n_nxt_s;
  logic                             busy_r, busy_nxt_s;
  logic                             cycle_done_r, cycle_done_nxt_s;
  logic                             accept_s;

  // Race-logic test: a lane is high once the gamma count has reached its spike time.
  function automatic logic has_risen(input logic [TIME_WIDTH-1:0] t,
                                     input logic [TIME_WIDTH-1:0] k);
    return (t <= k);
  endfunction

  assign in_ready = grst && (state_r == IDLE);
  assign accept_s = in_valid && in_ready;

  assign edges       = edges_r;
  assign sel_greater = sel_greater_r;
  assign sel_lesser  = sel_lesser_r;
  assign gamma_rst_n = gamma_rst_n_r;
  assign busy        = busy_r;
  assign cycle_done  = cycle_done_r;

  // State, counter, captured vector and registered outputs.
  always_ff @(posedge aclk) begin
    if (!grst) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_WIDTH{1'b0}};
      times_r       <= {(NUM_INPUTS*TIME_WIDTH){1'b0}};
      t_greater_r   <= {TIME_WIDTH{1'b0}};
      t_lesser_r    <= {TIME_WIDTH{1'b0}};
      edges_r       <= {NUM_INPUTS{1'b0}};
      sel_greater_r <= 1'b0;
      sel_lesser_r  <= 1'b0;
      gamma_rst_n_r <= 1'b0;
      busy_r        <= 1'b0;
      cycle_done_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      edges_r       <= edges_nxt_s;
      sel_greater_r <= sel_greater_nxt_s;
      sel_lesser_r  <= sel_lesser_nxt_s;
      gamma_rst_n_r <= gamma_rst_n_nxt_s;
      busy_r        <= busy_nxt_s;
      cycle_done_r  <= cycle_done_nxt_s;
      if (accept_s) begin
        times_r     <= in_times;
        t_greater_r <= in_t_greater;
        t_lesser_r  <= in_t_lesser;
      end
    end
  end

  // Next state and gamma counter; the counter rests at zero outside RUN.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = {CNT_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    cnt_ext_s         = TIME_WIDTH'(cnt_nxt_s);
    edges_nxt_s       = edges_r;
    sel_greater_nxt_s = sel_greater_r;
    sel_lesser_nxt_s  = sel_lesser_r;
    gamma_rst_n_nxt_s = 1'b1;
    busy_nxt_s        = 1'b0;
    cycle_done_nxt_s  = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        busy_nxt_s = 1'b0;
      end
      CLEAR: begin
        edges_nxt_s       = {NUM_INPUTS{1'b0}};
        sel_greater_nxt_s = 1'b0;
        sel_lesser_nxt_s  = 1'b0;
        gamma_rst_n_nxt_s = 1'b0;
        busy_nxt_s        = 1'b1;
      end
      RUN: begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          edges_nxt_s[i] = has_risen(times_r[i*TIME_WIDTH +: TIME_WIDTH], cnt_ext_s);
        end
        sel_greater_nxt_s = has_risen(t_greater_r, cnt_ext_s);
        sel_lesser_nxt_s  = has_risen(t_lesser_r, cnt_ext_s);
        busy_nxt_s        = 1'b1;
        cycle_done_nxt_s  = (cnt_nxt_s == CNT_LAST);
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// tb_temporal_encoder: directed and randomized stimulus; each accepted vector pushes
// its expected rise times, and an independent monitor checks every cycle of the response.
`timescale 1ns/1ps
module tb_temporal_encoder;

  localparam int G  = 16;
  localparam int NI = 4;
  localparam int TW = 5;

  localparam int P_RST   = 0;
  localparam int P_IDLE  = 1;
  localparam int P_CLEAR = 2;
  localparam int P_RUN   = 3;

  logic              aclk = 1'b0;
  logic              grst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NI*TW-1:0]  in_times = '0;
  logic [TW-1:0]     in_t_greater = '0;
  logic [TW-1:0]     in_t_lesser = '0;
  logic [NI-1:0]     edges;
  logic              sel_greater, sel_lesser, gamma_rst_n, busy, cycle_done;

  temporal_encoder #(
    .GAMMA_CYCLE_WIDTH(G),
    .NUM_INPUTS(NI),
    .TIME_WIDTH(TW)
  ) dut (
    .aclk(aclk),
    .grst(grst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_times(in_times),
    .in_t_greater(in_t_greater),
    .in_t_lesser(in_t_lesser),
    .edges(edges),
    .sel_greater(sel_greater),
    .sel_lesser(sel_lesser),
    .gamma_rst_n(gamma_rst_n),
    .busy(busy),
    .cycle_done(cycle_done)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [NI-1:0][7:0] rise;
    logic [7:0]         rg;
    logic [7:0]         rl;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int accepted = 0, dones = 0, aborted = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // First gamma step at which a spike time is visible; G means it never rises.
  function automatic int rise_of(input int t);
    return (t < G) ? t : G;
  endfunction

  // ---------------- monitor ----------------
  int            phase = P_RST;
  int            k = 0;
  bit            grst_q = 1'b0;
  bit            hs_q = 1'b0;
  exp_t          cur = '0;
  logic [NI-1:0] exp_e = '0;
  logic [NI-1:0] prev_obs = '0;
  logic          exp_g = 1'b0, exp_l = 1'b0;

  always @(negedge aclk) begin
    if (!grst_q) begin
      if (phase == P_CLEAR || phase == P_RUN) aborted++;
      phase = P_RST;
      exp_e = '0; exp_g = 1'b0; exp_l = 1'b0;
    end else if ((phase == P_IDLE || phase == P_RST) && hs_q) begin
      phase = P_CLEAR;
    end else if (phase == P_CLEAR) begin
      phase = P_RUN; k = 0;
    end else if (phase == P_RUN && k < G-1) begin
      k++;
    end else begin
      phase = P_IDLE;
    end

    if (cycle_done) dones++;

    case (phase)
      P_RST: begin
        chk("rst_edges", int'(edges), 0);
        chk("rst_sel", int'({sel_greater, sel_lesser}), 0);
        chk("rst_gamma_rst_n", int'(gamma_rst_n), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cycle_done", int'(cycle_done), 0);
        chk("rst_in_ready", int'(in_ready), int'(grst));
      end
      P_IDLE: begin
        chk("idle_busy", int'(busy), 0);
        chk("idle_cycle_done", int'(cycle_done), 0);
        chk("idle_gamma_rst_n", int'(gamma_rst_n), 1);
        chk("idle_hold_edges", int'(edges), int'(exp_e));
        chk("idle_hold_sel", int'({sel_greater, sel_lesser}), int'({exp_g, exp_l}));
        chk("idle_in_ready", int'(in_ready), int'(grst));
      end
      P_CLEAR: begin
        if (sb_q.size() == 0) begin
          chk("clear_without_vector", 0, 1);
          cur = '0;
        end else begin
          cur = sb_q.pop_front();
        end
        exp_e = '0; exp_g = 1'b0; exp_l = 1'b0;
        chk("clear_edges", int'(edges), 0);
        chk("clear_sel", int'({sel_greater, sel_lesser}), 0);
        chk("clear_gamma_rst_n", int'(gamma_rst_n), 0);
        chk("clear_busy", int'(busy), 1);
        chk("clear_cycle_done", int'(cycle_done), 0);
        chk("clear_in_ready", int'(in_ready), 0);
      end
      default: begin
        for (int i = 0; i < NI; i++) exp_e[i] = (k >= int'(cur.rise[i]));
        exp_g = (k >= int'(cur.rg));
        exp_l = (k >= int'(cur.rl));
        chk("run_edges", int'(edges), int'(exp_e));
        chk("run_sel_greater", int'(sel_greater), int'(exp_g));
        chk("run_sel_lesser", int'(sel_lesser), int'(exp_l));
        chk("run_busy", int'(busy), 1);
        chk("run_gamma_rst_n", int'(gamma_rst_n), 1);
        chk("run_cycle_done", int'(cycle_done), (k == G-1) ? 1 : 0);
        chk("run_in_ready", int'(in_ready), 0);
        if (k > 0) chk("run_edge_fall", int'(prev_obs & ~edges), 0);
      end
    endcase

    prev_obs = edges;
    hs_q     = in_valid && in_ready;
    grst_q   = grst;
  end

  // ---------------- driver ----------------
  task automatic send(input logic [NI*TW-1:0] t, input logic [TW-1:0] g,
                      input logic [TW-1:0] l, output int acc);
    bit   ok;
    exp_t e;
    ok  = 1'b0;
    acc = -1;
    in_times = t; in_t_greater = g; in_t_lesser = l; in_valid = 1'b1;
    for (int b = 0; b < 200 && !ok; b++) begin
      @(negedge aclk);
      ok = in_ready;
      @(posedge aclk);
      #1;
    end
    in_valid = 1'b0;
    in_times = (NI*TW)'($urandom);
    chk("accept_timeout", int'(ok), 1);
    if (ok) begin
      for (int i = 0; i < NI; i++) e.rise[i] = 8'(rise_of(int'(t[i*TW +: TW])));
      e.rg = 8'(rise_of(int'(g)));
      e.rl = 8'(rise_of(int'(l)));
      sb_q.push_back(e);
      accepted++;
      acc = cyc;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int b = 0; b < 100 && !ok; b++) begin
      @(negedge aclk);
      ok = !busy;
    end
    @(posedge aclk);
    #1;
    chk("idle_timeout", int'(ok), 1);
  endtask

  function automatic logic [TW-1:0] rnd_time();
    if ($urandom_range(0, 5) == 0) return TW'($urandom_range(G, (1 << TW) - 1));
    return TW'($urandom_range(0, G-1));
  endfunction

  initial begin
    int a1, a2, gap;
    logic [NI*TW-1:0] t;

    repeat (3) @(posedge aclk);
    #1 grst = 1'b1;

    // basic encode: lanes {0,3,15,16}, greater 5, lesser 9
    t = {5'd16, 5'd15, 5'd3, 5'd0};
    send(t, 5'd5, 5'd9, a1);

    // backpressure: new vector raised at RUN k=4 and held
    repeat (5) @(posedge aclk);
    #1;
    send({NI{5'd2}}, 5'd2, 5'd2, a2);
    chk("b2b_accept_latency", a2 - a1, G + 2);
    wait_idle();

    // no-spike lanes
    send({NI{5'd31}}, 5'd16, 5'd0, a1);
    wait_idle();

    // reset mid-RUN at k=7, held 3 cycles, then a normal vector
    send({5'd1, 5'd6, 5'd9, 5'd12}, 5'd4, 5'd8, a1);
    repeat (8) @(posedge aclk);
    #1 grst = 1'b0;
    repeat (3) @(posedge aclk);
    #1 grst = 1'b1;
    send({5'd7, 5'd0, 5'd20, 5'd14}, 5'd3, 5'd15, a1);

    // soak with random gaps
    for (int n = 0; n < 200; n++) begin
      gap = int'($urandom_range(0, 3));
      for (int j = 0; j < gap; j++) begin
        @(posedge aclk);
        #1 in_times = (NI*TW)'($urandom);
      end
      for (int i = 0; i < NI; i++) t[i*TW +: TW] = rnd_time();
      send(t, rnd_time(), rnd_time(), a1);
    end

    wait_idle();
    repeat (2) @(posedge aclk);
    #1;
    chk("cycle_done_count", dones, accepted - aborted);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
